work_mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the single-port work buffer SRAM (4096 x 32) between three codec datapath requesters.
- Requester 0 is MDCT, requester 1 is spectral analysis, requester 2 is quantization control.
- Provides per-requester valid/ready request channels, routes 1-cycle-latency read data back to the owner, supports locked bursts, flags out-of-range accesses and counts contention.

---
 rtl/work_mem_arbiter_if.sv | 28 ++
 rtl/work_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_work_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/work_mem_arbiter_if.sv
// Requester-side handshake bundle for the work buffer arbiter.
// Slices of the flattened buses belong to requester i at [i*W +: W].
interface work_mem_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_wen;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  // Requesters drive the request channel and observe accepts/responses.
  modport master (
    output req_valid, req_addr, req_wdata, req_wen, req_lock,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // The arbiter consumes requests and returns accepts/responses.
  modport slave (
    input  req_valid, req_addr, req_wdata, req_wen, req_lock,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/work_mem_arbiter.sv
// Round-robin arbiter sharing the single-port work buffer SRAM between the
// MDCT (0), spectral analysis (1) and quantization control (2) datapaths.
// Supports locked bursts, out-of-range flagging and contention counting.
module work_mem_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arb_enable_i,
  work_mem_arbiter_if.slave   bus_io,
  output logic                sram_cs_o,
  output logic                sram_we_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  input  logic [DATA_W-1:0]   sram_rdata_i,
  output logic [NUM_REQ-1:0]  addr_err_o,
  output logic [15:0]         conflict_cnt_o,
  output logic                arb_busy_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IdxW-1:0] idx_t;

  idx_t               rr_ptr_q, rr_ptr_d;
  logic               lock_active_q, lock_active_d;
  idx_t               lock_owner_q, lock_owner_d;
  logic               rd_pend_q, rd_pend_d;
  idx_t               rd_owner_q, rd_owner_d;
  logic               rd_oor_q, rd_oor_d;
  logic [NUM_REQ-1:0] addr_err_q, addr_err_d;
  logic [15:0]        conflict_cnt_q, conflict_cnt_d;
  logic               arb_busy_q, arb_busy_d;

  logic              win_found;
  idx_t              win_idx;
  idx_t              cand;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_wen;
  logic              win_lock;
  logic              win_in_range;
  logic              xfer;

  // Winner select: the lock owner exclusively while locked, else the first
  // valid requester scanning upward from rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (lock_active_q) begin
      win_found = bus_io.req_valid[lock_owner_q];
      win_idx   = lock_owner_q;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = idx_t'((32'(rr_ptr_q) + k) % NUM_REQ);
        if (!win_found && bus_io.req_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // Mux the winning requester's slice out of the flattened buses.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_wen   = 1'b0;
    win_lock  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == idx_t'(i)) begin
        win_addr  = bus_io.req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = bus_io.req_wdata[i*DATA_W +: DATA_W];
        win_wen   = bus_io.req_wen[i];
        win_lock  = bus_io.req_lock[i];
      end
    end
  end

  assign win_in_range = (32'(win_addr) < MEM_DEPTH);
  // Gating with rst_n keeps every combinational output quiet during reset.
  assign xfer         = rst_n && arb_enable_i && win_found;

  // Accept and SRAM drive; out-of-range beats are accepted but never reach the SRAM.
  always_comb begin
    bus_io.req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus_io.req_ready[i] = xfer && (win_idx == idx_t'(i));
    end
    sram_cs_o    = xfer && win_in_range;
    sram_we_o    = sram_cs_o && win_wen;
    sram_addr_o  = sram_cs_o ? win_addr  : '0;
    sram_wdata_o = sram_cs_o ? win_wdata : '0;
  end

  // Next-state for pointer, lock, read pipeline, error pulse and counters.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    lock_active_d  = lock_active_q;
    lock_owner_d   = lock_owner_q;
    rd_pend_d      = 1'b0;
    rd_owner_d     = rd_owner_q;
    rd_oor_d       = 1'b0;
    addr_err_d     = '0;
    conflict_cnt_d = conflict_cnt_q;
    if (xfer) begin
      rr_ptr_d      = idx_t'((32'(win_idx) + 32'd1) % NUM_REQ);
      lock_active_d = win_lock;
      lock_owner_d  = win_idx;
      if (!win_wen) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = win_idx;
        rd_oor_d   = !win_in_range;
      end
      if (!win_in_range) begin
        addr_err_d[win_idx] = 1'b1;
      end
    end
    if (arb_enable_i && ($countones(bus_io.req_valid) > 1) && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
    arb_busy_d = lock_active_d || rd_pend_d;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      lock_active_q  <= 1'b0;
      lock_owner_q   <= '0;
      rd_pend_q      <= 1'b0;
      rd_owner_q     <= '0;
      rd_oor_q       <= 1'b0;
      addr_err_q     <= '0;
      conflict_cnt_q <= '0;
      arb_busy_q     <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      lock_active_q  <= lock_active_d;
      lock_owner_q   <= lock_owner_d;
      rd_pend_q      <= rd_pend_d;
      rd_owner_q     <= rd_owner_d;
      rd_oor_q       <= rd_oor_d;
      addr_err_q     <= addr_err_d;
      conflict_cnt_q <= conflict_cnt_d;
      arb_busy_q     <= arb_busy_d;
    end
  end

  // Response routing: SRAM data lands the cycle after the access; an
  // out-of-range read answers with zero instead.
  always_comb begin
    bus_io.rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus_io.rsp_valid[i] = rd_pend_q && (rd_owner_q == idx_t'(i));
    end
    bus_io.rsp_rdata = (rd_pend_q && !rd_oor_q) ? sram_rdata_i : '0;
  end

  assign addr_err_o     = addr_err_q;
  assign conflict_cnt_o = conflict_cnt_q;
  assign arb_busy_o     = arb_busy_q;

endmodule

// File: tb/tb_work_mem_arbiter.sv
// Self-checking bench for work_mem_arbiter: read responses are predicted into
// a queue as requests are accepted and matched when rsp_valid appears.
module tb_work_mem_arbiter;
  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_DEPTH = 2048;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        arb_enable = 1'b0;
  logic        sram_cs;
  logic        sram_we;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic [2:0]  addr_err;
  logic [15:0] conflict_cnt;
  logic        arb_busy;
  logic [31:0] mem [4096];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0]  oh;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  work_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  work_mem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arb_enable_i   (arb_enable),
    .bus_io         (bus),
    .sram_cs_o      (sram_cs),
    .sram_we_o      (sram_we),
    .sram_addr_o    (sram_addr),
    .sram_wdata_o   (sram_wdata),
    .sram_rdata_i   (sram_rdata),
    .addr_err_o     (addr_err),
    .conflict_cnt_o (conflict_cnt),
    .arb_busy_o     (arb_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [11:0] a);
    return {8'h5A, a, ~a};
  endfunction

  // Expected read data: addresses read by this bench are never written.
  function automatic logic [31:0] exp_read(input logic [11:0] a);
    if (32'(a) >= MEM_DEPTH) return 32'h0;
    if (a == 12'h4C0) return 32'hDEADBEEF;
    return pat(a);
  endfunction

  // SRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: every predicted read must appear exactly one cycle later.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_owner", 32'(bus.rsp_valid), 32'(e.oh));
          check("rsp_data", bus.rsp_rdata, e.data);
        end
      end else if (exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_missing", 32'(bus.rsp_valid), 32'(e.oh));
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic w, input logic l,
                         input logic [11:0] a, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_wen[i]            = w;
    bus.req_lock[i]           = l;
    bus.req_addr[i*12 +: 12]  = a;
    bus.req_wdata[i*32 +: 32] = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_wen   = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  // Settle combinational logic, check the accept vector, predict read responses.
  task automatic eval(input string tag, input logic [2:0] exp_ready);
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
    for (int i = 0; i < 3; i++) begin
      if (exp_ready[i] && !bus.req_wen[i]) begin
        rsp_t e;
        e.oh   = exp_ready;
        e.data = exp_read(bus.req_addr[i*12 +: 12]);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n      = 1'b0;
    clear_reqs();
    arb_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = pat(12'(a));
    mem[12'h4C0] = 32'hDEADBEEF;
    clear_reqs();

    // Reset values, with requests pending while reset is held.
    rst_n = 1'b0;
    arb_enable = 1'b1;
    @(negedge clk);
    set_req(0, 1, 0, 0, 12'h010, 0);
    set_req(1, 1, 0, 1, 12'h020, 0);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_cs", 32'(sram_cs), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    check("rst_cnt", 32'(conflict_cnt), 32'h0);
    check("rst_busy", 32'(arb_busy), 32'h0);

    // Single read by requester 1.
    reset_dut();
    set_req(1, 1, 0, 0, 12'h4C0, 0);
    eval("rd1", 3'b010);
    check("rd1_cs", 32'(sram_cs), 32'h1);
    check("rd1_we", 32'(sram_we), 32'h0);
    check("rd1_addr", 32'(sram_addr), 32'h4C0);
    tick();
    clear_reqs();
    check("rd1_busy", 32'(arb_busy), 32'h1);
    tick();
    check("rd1_busy_idle", 32'(arb_busy), 32'h0);

    // Round robin with all three continuously valid.
    reset_dut();
    set_req(0, 1, 0, 0, 12'h010, 0);
    set_req(1, 1, 0, 0, 12'h020, 0);
    set_req(2, 1, 0, 0, 12'h030, 0);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] oh;
      oh = 3'b001 << (k % 3);
      eval("rr", oh);
      tick();
    end
    clear_reqs();
    check("rr_cnt", 32'(conflict_cnt), 32'd6);
    tick();

    // Locked write burst by requester 2, including a stall and a disabled cycle.
    reset_dut();
    set_req(2, 1, 1, 1, 12'h100, 32'h1111_0000);
    eval("lk0", 3'b100);
    check("lk0_we", 32'(sram_we), 32'h1);
    check("lk0_wdata", sram_wdata, 32'h1111_0000);
    tick();
    check("lk0_busy", 32'(arb_busy), 32'h1);
    set_req(0, 1, 0, 0, 12'h050, 0);
    set_req(1, 1, 0, 0, 12'h060, 0);
    set_req(2, 1, 1, 1, 12'h101, 32'h1111_0001);
    eval("lk1", 3'b100);
    tick();
    set_req(2, 0, 1, 1, 12'h102, 32'h1111_0002);
    eval("lk_stall", 3'b000);
    check("lk_stall_cs", 32'(sram_cs), 32'h0);
    tick();
    check("lk_stall_busy", 32'(arb_busy), 32'h1);
    arb_enable = 1'b0;
    set_req(2, 1, 1, 1, 12'h102, 32'h1111_0002);
    eval("lk_dis", 3'b000);
    tick();
    arb_enable = 1'b1;
    eval("lk2", 3'b100);
    tick();
    set_req(2, 1, 1, 0, 12'h103, 32'h1111_0003);
    eval("lk3", 3'b100);
    tick();
    check("lk_rel_busy", 32'(arb_busy), 32'h0);
    eval("lk_after0", 3'b001);
    tick();
    eval("lk_after1", 3'b010);
    tick();
    clear_reqs();
    tick();
    check("lk_mem", mem[12'h103], 32'h1111_0003);

    // Out-of-range accesses and the in-range boundary.
    reset_dut();
    set_req(0, 1, 0, 0, 12'hFFF, 0);
    eval("oor_rd", 3'b001);
    check("oor_rd_cs", 32'(sram_cs), 32'h0);
    tick();
    clear_reqs();
    check("oor_rd_err", 32'(addr_err), 32'h1);
    tick();
    check("oor_err_clr", 32'(addr_err), 32'h0);
    set_req(1, 1, 1, 0, 12'h800, 32'hBAD0_BAD0);
    eval("oor_wr", 3'b010);
    check("oor_wr_cs", 32'(sram_cs), 32'h0);
    tick();
    clear_reqs();
    check("oor_wr_err", 32'(addr_err), 32'h2);
    set_req(2, 1, 0, 0, 12'h7FF, 0);
    eval("edge_rd", 3'b100);
    check("edge_rd_cs", 32'(sram_cs), 32'h1);
    tick();
    clear_reqs();
    check("edge_rd_err", 32'(addr_err), 32'h0);
    tick();

    // Alternating read (req 1) and write (req 0).
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      clear_reqs();
      if (k % 2 == 0) begin
        set_req(1, 1, 0, 0, 12'h400, 0);
        eval("alt_rd", 3'b010);
      end else begin
        set_req(0, 1, 1, 0, 12'h480, 32'hC0C0_0000 + 32'(k));
        eval("alt_wr", 3'b001);
        check("alt_wr_we", 32'(sram_we), 32'h1);
      end
      tick();
    end
    clear_reqs();
    tick();

    // Reset the cycle after a locked read is accepted.
    reset_dut();
    set_req(1, 1, 0, 1, 12'h4C0, 0);
    eval("rstmid", 3'b010);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    set_req(0, 1, 0, 0, 12'h020, 0);
    #1;
    check("rstmid_rsp", 32'(bus.rsp_valid), 32'h0);
    check("rstmid_rdata", bus.rsp_rdata, 32'h0);
    check("rstmid_busy", 32'(arb_busy), 32'h0);
    check("rstmid_ready", 32'(bus.req_ready), 32'h0);
    check("rstmid_cs", 32'(sram_cs), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    eval("rstmid_nolock", 3'b001);
    tick();
    clear_reqs();
    tick();
    tick();
    check("q_drain", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
